// File: rtl/mac_pattern_detector.sv
// Pipelined unsigned multiply / multiply-accumulate with a maskable pattern detector on the result.
// Three register stages (inputs, product, result+flags); c itself is the accumulator.
module mac_pattern_detector #(
  parameter int unsigned DW          = 8,
  parameter int unsigned GW          = 4,
  parameter int unsigned CNTW        = 8,
  parameter int unsigned DEF_PATTERN = 18,
  localparam int unsigned PW         = 2*DW + GW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic            mode,
  input  logic            acc_clr,
  input  logic            cfg_we,
  input  logic [PW-1:0]   cfg_pattern,
  input  logic [PW-1:0]   cfg_mask,
  input  logic            cnt_clr,
  output logic            out_valid,
  output logic [PW-1:0]   c,
  output logic            pattern_detect,
  output logic            patternb_detect,
  output logic            acc_ovf,
  output logic [CNTW-1:0] match_cnt
);

  localparam logic [PW-1:0] DEF_PAT = PW'(DEF_PATTERN);

  logic            v1, m1, clr1;
  logic [DW-1:0]   a1, b1;
  logic            v2, m2, clr2;
  logic [2*DW-1:0] p2;
  logic [PW-1:0]   pattern_q, mask_q;

  logic [PW-1:0]   prod_ext;
  logic [PW:0]     sum;
  logic [PW-1:0]   c_nxt;
  logic            pd_nxt, pbd_nxt;

  // S1: input capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      m1   <= 1'b0;
      clr1 <= 1'b0;
      a1   <= '0;
      b1   <= '0;
    end else begin
      v1   <= in_valid;
      m1   <= mode;
      clr1 <= acc_clr;
      a1   <= a;
      b1   <= b;
    end
  end

  // S2: product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      m2   <= 1'b0;
      clr2 <= 1'b0;
      p2   <= '0;
    end else begin
      v2   <= v1;
      m2   <= m1;
      clr2 <= clr1;
      p2   <= {{DW{1'b0}}, a1} * {{DW{1'b0}}, b1};
    end
  end

  // Flags are derived from the value c is about to take, so they always match it.
  always_comb begin
    prod_ext = {{GW{1'b0}}, p2};
    sum      = {1'b0, c} + {1'b0, prod_ext};
    c_nxt    = (m2 && !clr2) ? sum[PW-1:0] : prod_ext;
    pd_nxt   = ((c_nxt ^ pattern_q) & ~mask_q) == '0;
    pbd_nxt  = ((c_nxt ^ ~pattern_q) & ~mask_q) == '0;
  end

  // S3: result, flags, sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      c               <= '0;
      pattern_detect  <= 1'b0;
      patternb_detect <= 1'b0;
      acc_ovf         <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        c               <= c_nxt;
        pattern_detect  <= pd_nxt;
        patternb_detect <= pbd_nxt;
        if (m2) begin
          if (clr2)        acc_ovf <= 1'b0;
          else if (sum[PW]) acc_ovf <= 1'b1;
        end
      end else begin
        pattern_detect  <= 1'b0;
        patternb_detect <= 1'b0;
      end
    end
  end

  // Counter advances on the same edge the matching result is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (v2 && pd_nxt && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= DEF_PAT;
      mask_q    <= '0;
    end else if (cfg_we) begin
      pattern_q <= cfg_pattern;
      mask_q    <= cfg_mask;
    end
  end

endmodule

// File: tb/tb_mac_pattern_detector.sv
// Directed bench for mac_pattern_detector: latency, default/masked/inverse patterns,
// MAC with bubbles, overflow, counter saturation/clear, reset mid-stream.
module tb_mac_pattern_detector;

  localparam int unsigned DW   = 8;
  localparam int unsigned GW   = 4;
  localparam int unsigned CNTW = 2;
  localparam int unsigned PW   = 2*DW + GW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [DW-1:0]   a, b;
  logic            mode, acc_clr;
  logic            cfg_we;
  logic [PW-1:0]   cfg_pattern, cfg_mask;
  logic            cnt_clr;
  logic            out_valid;
  logic [PW-1:0]   c;
  logic            pattern_detect, patternb_detect, acc_ovf;
  logic [CNTW-1:0] match_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mac_pattern_detector #(
    .DW(DW), .GW(GW), .CNTW(CNTW), .DEF_PATTERN(18)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .mode(mode), .acc_clr(acc_clr), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .c(c), .pattern_detect(pattern_detect),
    .patternb_detect(patternb_detect), .acc_ovf(acc_ovf), .match_cnt(match_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] ia, input logic [7:0] ib, input logic im, input logic ic);
    in_valid = 1'b1;
    a        = ia;
    b        = ib;
    mode     = im;
    acc_clr  = ic;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    mode     = 1'b0;
    acc_clr  = 1'b0;
  endtask

  // One isolated sample; returns just after the edge that presents it on the outputs.
  task automatic run1(input logic [7:0] ia, input logic [7:0] ib, input logic im, input logic ic);
    drive(ia, ib, im, ic);
    tick();
    idle();
    tick();
    tick();
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [31:0] cc,
                         input logic pd, input logic pbd);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".c"}, 32'(c), cc);
    chk({tag, ".pd"}, 32'(pattern_detect), 32'(pd));
    chk({tag, ".pbd"}, 32'(patternb_detect), 32'(pbd));
  endtask

  task automatic cfg(input logic [PW-1:0] pat, input logic [PW-1:0] msk);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_mask    = msk;
    tick();
    cfg_we      = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    idle();
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    cfg_mask    = '0;
    cnt_clr     = 1'b0;

    // T1: reset holds everything at zero while inputs toggle
    for (int i = 0; i < 3; i++) begin
      drive(8'(i + 1), 8'd7, i[0], 1'b1);
      tick();
    end
    chk_out("t1_rst", 1'b0, 0, 1'b0, 1'b0);
    chk("t1_rst.acc_ovf", 32'(acc_ovf), 0);
    chk("t1_rst.cnt", 32'(match_cnt), 0);
    idle();
    rst_n = 1'b1;
    tick();
    chk("t1_idle.out_valid", 32'(out_valid), 0);

    // T2: default pattern 18, latency exactly 3
    drive(8'd3, 8'd6, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("t2_lat2.out_valid", 32'(out_valid), 0);
    tick();
    chk_out("t2_18", 1'b1, 18, 1'b1, 1'b0);
    chk("t2_18.cnt", 32'(match_cnt), 1);
    tick();
    chk("t2_after.out_valid", 32'(out_valid), 0);
    run1(8'd3, 8'd5, 1'b0, 1'b0);
    chk_out("t2_15", 1'b1, 15, 1'b0, 1'b0);
    chk("t2_15.cnt", 32'(match_cnt), 1);

    // T3: masked compare, inverse pattern, all-ones mask
    cfg(20'h00010, 20'h0000F);
    run1(8'd4, 8'd5, 1'b0, 1'b0);
    chk_out("t3_20", 1'b1, 20, 1'b1, 1'b0);
    chk("t3_20.cnt", 32'(match_cnt), 2);
    run1(8'd4, 8'd8, 1'b0, 1'b0);
    chk_out("t3_32", 1'b1, 32, 1'b0, 1'b0);
    cfg(~20'd20, '0);
    run1(8'd4, 8'd5, 1'b0, 1'b0);
    chk_out("t3_inv", 1'b1, 20, 1'b0, 1'b1);
    cfg(20'd99, '1);
    run1(8'd3, 8'd5, 1'b0, 1'b0);
    chk_out("t3_allmask", 1'b1, 15, 1'b1, 1'b1);
    chk("t3_allmask.cnt", 32'(match_cnt), 3);

    // T4: MAC stream with a bubble; cfg_we coinciding with a compare
    cnt_clr = 1'b1;
    cfg(20'd26, '0);
    cnt_clr = 1'b0;
    chk("t4_clr.cnt", 32'(match_cnt), 0);
    drive(8'd2, 8'd3, 1'b1, 1'b1);
    tick();
    drive(8'd4, 8'd5, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    chk_out("t4_6", 1'b1, 6, 1'b0, 1'b0);
    drive(8'd1, 8'd1, 1'b1, 1'b0);
    tick();
    chk_out("t4_26", 1'b1, 26, 1'b1, 1'b0);
    chk("t4_26.cnt", 32'(match_cnt), 1);
    idle();
    tick();
    chk_out("t4_bubble", 1'b0, 26, 1'b0, 1'b0);
    chk("t4_bubble.cnt", 32'(match_cnt), 1);
    cfg_we      = 1'b1;
    cfg_pattern = 20'd27;
    cfg_mask    = '0;
    tick();
    cfg_we      = 1'b0;
    chk_out("t4_27_oldpat", 1'b1, 27, 1'b0, 1'b0);
    chk("t4_27.acc_ovf", 32'(acc_ovf), 0);
    run1(8'd0, 8'd0, 1'b1, 1'b0);
    chk_out("t4_27_newpat", 1'b1, 27, 1'b1, 1'b0);
    chk("t4_27_newpat.cnt", 32'(match_cnt), 2);

    // T5: 17 x 255*255 wraps the 20-bit accumulator
    for (int i = 0; i < 17; i++) begin
      drive(8'd255, 8'd255, 1'b1, (i == 0));
      tick();
    end
    idle();
    tick();
    chk("t5_16.c", 32'(c), 1040400);
    chk("t5_16.acc_ovf", 32'(acc_ovf), 0);
    tick();
    chk("t5_17.c", 32'(c), 56849);
    chk("t5_17.acc_ovf", 32'(acc_ovf), 1);
    run1(8'd1, 8'd1, 1'b1, 1'b0);
    chk("t5_sticky.c", 32'(c), 56850);
    chk("t5_sticky.acc_ovf", 32'(acc_ovf), 1);
    run1(8'd1, 8'd1, 1'b0, 1'b0);
    chk("t5_mode0.acc_ovf", 32'(acc_ovf), 1);
    run1(8'd2, 8'd2, 1'b1, 1'b1);
    chk("t5_load.c", 32'(c), 4);
    chk("t5_load.acc_ovf", 32'(acc_ovf), 0);

    // T5: counter saturation and clear-over-increment
    cnt_clr = 1'b1;
    cfg('0, '1);
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(8'd1, 8'd1, 1'b0, 1'b0);
      tick();
    end
    idle();
    tick();
    tick();
    chk("t5_sat.cnt", 32'(match_cnt), 3);
    drive(8'd1, 8'd1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t5_clrpri.pd", 32'(pattern_detect), 1);
    chk("t5_clrpri.cnt", 32'(match_cnt), 0);

    // T6: reset with samples in flight
    drive(8'd3, 8'd6, 1'b0, 1'b0);
    tick();
    drive(8'd4, 8'd6, 1'b0, 1'b0);
    tick();
    drive(8'd5, 8'd6, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_async.c", 32'(c), 0);
    idle();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t6_flush.out_valid", 32'(out_valid), 0);
      tick();
    end
    run1(8'd3, 8'd6, 1'b0, 1'b0);
    chk_out("t6_defpat", 1'b1, 18, 1'b1, 1'b0);
    chk("t6_defpat.cnt", 32'(match_cnt), 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
